// File: rtl/disp_sched.sv
// Display scheduler: rotates four debug sources onto the 7-segment datapath
// on a dwell timer or step input, with a pre-empting urgent requester.
module disp_sched #(
    parameter int DWELL = 50000000,
    parameter int HOLD  = 25000000,
    parameter int CW    = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] src_data,
    input  logic [3:0]   src_valid,
    input  logic         auto_mode,
    input  logic         step,
    input  logic         urg_req,
    input  logic [31:0]  urg_data,
    output logic         urg_ack,
    output logic [31:0]  out_data,
    output logic         out_en,
    output logic [1:0]   out_sel,
    output logic         busy_urg
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_URGENT = 2'd2;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   data_q, data_d;
    logic          en_q, en_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          step_q, step_d;

    logic          step_edge;
    logic [1:0]    adv_sel;
    logic [1:0]    low_sel;
    logic [1:0]    resume_sel;
    logic [1:0]    load_sel;
    logic          load_src;

    // Next valid index strictly after cur, wrapping; falls back to cur itself.
    function automatic logic [1:0] next_valid(input logic [1:0] cur, input logic [3:0] v);
        logic [1:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (!found && v[cur + 2'(i)]) begin
                res   = cur + 2'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] lowest_valid(input logic [3:0] v);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) res = 2'(i);
        end
        return res;
    endfunction

    assign step_edge  = step & ~step_q;
    assign adv_sel    = next_valid(sel_q, src_valid);
    assign low_sel    = lowest_valid(src_valid);
    assign resume_sel = src_valid[sel_q] ? sel_q : adv_sel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        data_d   = data_q;
        en_d     = 1'b0;
        ack_d    = 1'b0;
        busy_d   = 1'b0;
        step_d   = step;
        load_sel = sel_q;
        load_src = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (urg_req) begin
                    state_d = ST_URGENT;
                    data_d  = urg_data;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end else if (|src_valid) begin
                    state_d  = ST_SHOW;
                    sel_d    = low_sel;
                    load_sel = low_sel;
                    load_src = 1'b1;
                    en_d     = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_SHOW: begin
                if (urg_req) begin
                    state_d = ST_URGENT;
                    data_d  = urg_data;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end else if (src_valid == 4'b0000) begin
                    state_d = ST_IDLE;
                end else begin
                    en_d     = 1'b1;
                    load_src = 1'b1;
                    // Step edge, lost source and dwell expiry all share one target.
                    if (step_edge || !src_valid[sel_q] || (auto_mode && cnt_q == DWELL_LAST)) begin
                        sel_d    = adv_sel;
                        load_sel = adv_sel;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = auto_mode ? cnt_q + CW'(1) : '0;
                    end
                end
            end
            ST_URGENT: begin
                busy_d = 1'b1;
                if (!urg_req && cnt_q == HOLD_LAST) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    if (|src_valid) begin
                        state_d  = ST_SHOW;
                        sel_d    = resume_sel;
                        load_sel = resume_sel;
                        load_src = 1'b1;
                        en_d     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_src) begin
            data_d = src_data[{load_sel, 5'b00000} +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            data_q  <= 32'd0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
        end
    end

    assign urg_ack  = ack_q;
    assign out_data = data_q;
    assign out_en   = en_q;
    assign out_sel  = sel_q;
    assign busy_urg = busy_q;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: hand vectors for the documented scenarios, then
// random traffic compared against a behavioural model of the scheduling rules.
module tb_disp_sched;

    localparam int DWELL = 4;
    localparam int HOLD  = 3;
    localparam int CW    = 4;

    logic         clk;
    logic         rst;
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic         auto_mode;
    logic         step;
    logic         urg_req;
    logic [31:0]  urg_data;
    logic         urg_ack;
    logic [31:0]  out_data;
    logic         out_en;
    logic [1:0]   out_sel;
    logic         busy_urg;

    int checks_total;
    int checks_passed;

    disp_sched #(.DWELL(DWELL), .HOLD(HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .auto_mode (auto_mode),
        .step      (step),
        .urg_req   (urg_req),
        .urg_data  (urg_data),
        .urg_ack   (urg_ack),
        .out_data  (out_data),
        .out_en    (out_en),
        .out_sel   (out_sel),
        .busy_urg  (busy_urg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = idle, 1 = showing, 2 = urgent.
    int          m_mode;
    int          m_sel;
    int          m_shown;
    int          m_held;
    logic [31:0] m_data;
    bit          m_en;
    bit          m_ack;
    bit          m_busy;
    bit          m_prev_step;

    function automatic int m_next(input int cur, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    function automatic int m_lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_shown = 0; m_held = 0;
        m_data = 32'd0; m_en = 0; m_ack = 0; m_busy = 0; m_prev_step = 0;
    endtask

    task automatic model_grant();
        m_mode = 2; m_data = urg_data; m_ack = 1; m_busy = 1; m_en = 1; m_held = 0;
    endtask

    task automatic model_show(input int idx);
        m_mode = 1; m_sel = idx; m_data = src_data[32*idx +: 32]; m_en = 1;
    endtask

    task automatic model_step();
        bit rose;
        rose = step && !m_prev_step;
        m_prev_step = step;
        m_ack = 0;
        m_en  = 0;
        if (m_mode == 0) begin
            if (urg_req) model_grant();
            else if (src_valid != 0) begin
                model_show(m_lowest(src_valid));
                m_shown = 0;
            end
        end else if (m_mode == 1) begin
            if (urg_req) model_grant();
            else if (src_valid == 0) m_mode = 0;
            else if (rose || !src_valid[m_sel] || (auto_mode && m_shown == DWELL - 1)) begin
                model_show(m_next(m_sel, src_valid));
                m_shown = 0;
            end else begin
                model_show(m_sel);
                m_shown = auto_mode ? m_shown + 1 : 0;
            end
        end else begin
            if (!urg_req && m_held == HOLD - 1) begin
                m_busy = 0;
                if (src_valid == 0) m_mode = 0;
                else begin
                    model_show(src_valid[m_sel] ? m_sel : m_next(m_sel, src_valid));
                    m_shown = 0;
                end
            end else if (m_held < HOLD - 1) begin
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic a, input logic s,
                                 input logic u, input logic [31:0] ud);
        src_valid = v; auto_mode = a; step = s; urg_req = u; urg_data = ud;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic logic [63:0] dut_vec();
        return {27'd0, urg_ack, busy_urg, out_en, out_sel, out_data};
    endfunction

    function automatic logic [63:0] mk_vec(input bit ack, input bit busy, input bit en,
                                           input logic [1:0] sel, input logic [31:0] d);
        return {27'd0, ack, busy, en, sel, d};
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    typedef struct {
        logic [3:0]  valid;
        logic        step_in;
        logic [1:0]  exp_sel;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        model_reset();
        rst      = 1'b0;
        src_data = {pat(3), pat(2), pat(1), pat(0)};
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_state", dut_vec(), 64'd0);
        rst = 1'b1;

        // Manual stepping over sources 1 and 3, then losing sources.
        vecs[0]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 32'd0};
        vecs[1]  = '{4'b1010, 1'b0, 2'd1, 1'b1, pat(1)};
        vecs[2]  = '{4'b1010, 1'b0, 2'd1, 1'b1, pat(1)};
        vecs[3]  = '{4'b1010, 1'b1, 2'd3, 1'b1, pat(3)};
        vecs[4]  = '{4'b1010, 1'b0, 2'd3, 1'b1, pat(3)};
        vecs[5]  = '{4'b1010, 1'b1, 2'd1, 1'b1, pat(1)};
        vecs[6]  = '{4'b1010, 1'b1, 2'd1, 1'b1, pat(1)};
        vecs[7]  = '{4'b1010, 1'b0, 2'd1, 1'b1, pat(1)};
        vecs[8]  = '{4'b1010, 1'b1, 2'd3, 1'b1, pat(3)};
        vecs[9]  = '{4'b0100, 1'b0, 2'd2, 1'b1, pat(2)};
        vecs[10] = '{4'b0101, 1'b0, 2'd2, 1'b1, pat(2)};
        vecs[11] = '{4'b0001, 1'b0, 2'd0, 1'b1, pat(0)};
        vecs[12] = '{4'b0000, 1'b0, 2'd0, 1'b0, pat(0)};
        for (int i = 0; i < 13; i++) begin
            if (i == 9) begin
                for (int j = 0; j < 100; j++) begin
                    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0, 32'd0);
                    cyc();
                end
                checkOutput("manual_no_step_100", dut_vec(), mk_vec(0, 0, 1, 2'd3, pat(3)));
            end
            applyStimulus(vecs[i].valid, 1'b0, vecs[i].step_in, 1'b0, 32'd0);
            cyc();
            checkOutput($sformatf("table_%0d", i), dut_vec(),
                        mk_vec(0, 0, vecs[i].exp_en, vecs[i].exp_sel, vecs[i].exp_data));
        end

        // Auto rotation: each source for DWELL clocks.
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 17; k++) begin
            cyc();
            checkOutput($sformatf("auto_%0d", k), dut_vec(), mk_vec(0, 0, 1, 2'((k / 4) % 4), pat((k / 4) % 4)));
        end

        // Single-cycle urgent request while showing source 1.
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc();
        checkOutput("move_to_sel1", dut_vec(), mk_vec(0, 0, 1, 2'd1, pat(1)));
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc();
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cyc();
        checkOutput("urg_grant", dut_vec(), mk_vec(1, 1, 1, 2'd1, 32'hDEAD_BEEF));
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        checkOutput("urg_hold1", dut_vec(), mk_vec(0, 1, 0, 2'd1, 32'hDEAD_BEEF));
        cyc();
        checkOutput("urg_hold2", dut_vec(), mk_vec(0, 1, 0, 2'd1, 32'hDEAD_BEEF));
        cyc();
        checkOutput("urg_exit", dut_vec(), mk_vec(0, 0, 1, 2'd1, pat(1)));
        cyc();
        checkOutput("urg_resume", dut_vec(), mk_vec(0, 0, 1, 2'd1, pat(1)));

        // Urgent, step edge and dwell expiry on the same edge.
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) cyc();
        checkOutput("combo_pre", dut_vec(), mk_vec(0, 0, 1, 2'd1, pat(1)));
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
        cyc();
        checkOutput("combo_grant", dut_vec(), mk_vec(1, 1, 1, 2'd1, 32'hCAFE_F00D));
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc();
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        cyc();
        checkOutput("combo_exit", dut_vec(), mk_vec(0, 0, 1, 2'd1, pat(1)));

        // Asynchronous reset in the middle of an urgent hold.
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        cyc();
        checkOutput("reset_pre_urg", dut_vec(), mk_vec(1, 1, 1, 2'd1, 32'h1234_5678));
        #2 rst = 1'b0;
        #1 checkOutput("async_reset", dut_vec(), 64'd0);
        model_reset();
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        cyc();
        checkOutput("post_reset_sel2", dut_vec(), mk_vec(0, 0, 1, 2'd2, pat(2)));

        // Random traffic against the behavioural model.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] v;
            v = src_valid;
            if ($urandom_range(7) == 0) v = 4'($urandom);
            src_data = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(v,
                          ($urandom_range(19) == 0) ? ~auto_mode : auto_mode,
                          ($urandom_range(2) == 0) ? ~step : step,
                          urg_req ? ($urandom_range(2) != 0) : ($urandom_range(11) == 0),
                          $urandom);
            cyc();
            checkOutput($sformatf("random_%0d", n), dut_vec(),
                        mk_vec(m_ack, m_busy, m_en, 2'(m_sel), m_data));
        end

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
